// File: rtl/rv32i_mem_axil_bridge.sv
// MEM-stage IO request to AXI-Lite master bridge with one outstanding transaction.
// Each accepted load or store produces exactly one rsp_valid pulse.
module rv32i_mem_axil_bridge #(
    parameter int          ADDR_WIDTH = 32,
    parameter int          DATA_WIDTH = 32,
    parameter logic [2:0]  PROT       = 3'b000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_we,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic [DATA_WIDTH-1:0]     req_wdata,
    input  logic [DATA_WIDTH/8-1:0]   req_wstrb,
    output logic                      rsp_valid,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic                      rsp_err,
    output logic [ADDR_WIDTH-1:0]     s_axil_io_awaddr,
    output logic [2:0]                s_axil_io_awprot,
    output logic                      s_axil_io_awvalid,
    input  logic                      s_axil_io_awready,
    output logic [DATA_WIDTH-1:0]     s_axil_io_wdata,
    output logic [DATA_WIDTH/8-1:0]   s_axil_io_wstrb,
    output logic                      s_axil_io_wvalid,
    input  logic                      s_axil_io_wready,
    input  logic [1:0]                s_axil_io_bresp,
    input  logic                      s_axil_io_bvalid,
    output logic                      s_axil_io_bready,
    output logic [ADDR_WIDTH-1:0]     s_axil_io_araddr,
    output logic [2:0]                s_axil_io_arprot,
    output logic                      s_axil_io_arvalid,
    input  logic                      s_axil_io_arready,
    input  logic [DATA_WIDTH-1:0]     s_axil_io_rdata,
    input  logic [1:0]                s_axil_io_rresp,
    input  logic                      s_axil_io_rvalid,
    output logic                      s_axil_io_rready
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [2:0] {IDLE, WADDR_DATA, WRESP, RADDR, RDATA} state_t;

    state_t                  state_reg, state_next;
    logic                    awvalid_reg, wvalid_reg, arvalid_reg;
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic [DATA_WIDTH-1:0]   wdata_reg;
    logic [STRB_WIDTH-1:0]   wstrb_reg;
    logic                    rsp_valid_reg, rsp_err_reg;
    logic [DATA_WIDTH-1:0]   rsp_rdata_reg;
    logic                    accept, aw_done, w_done, b_hs, r_hs;
    logic                    unused_resp_bits;

    assign accept  = req_valid && req_ready;
    // A channel counts as done once its valid has dropped or it handshakes now.
    assign aw_done = !awvalid_reg || s_axil_io_awready;
    assign w_done  = !wvalid_reg  || s_axil_io_wready;
    assign b_hs    = (state_reg == WRESP) && s_axil_io_bvalid;
    assign r_hs    = (state_reg == RDATA) && s_axil_io_rvalid;
    assign unused_resp_bits = ^{s_axil_io_bresp[0], s_axil_io_rresp[0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:       if (req_valid) state_next = req_we ? WADDR_DATA : RADDR;
            WADDR_DATA: if (aw_done && w_done) state_next = WRESP;
            WRESP:      if (s_axil_io_bvalid) state_next = IDLE;
            RADDR:      if (s_axil_io_arready) state_next = RDATA;
            RDATA:      if (s_axil_io_rvalid) state_next = IDLE;
            default:    state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready        = (state_reg == IDLE);
        s_axil_io_bready = (state_reg == WRESP);
        s_axil_io_rready = (state_reg == RDATA);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            awvalid_reg   <= 1'b0;
            wvalid_reg    <= 1'b0;
            arvalid_reg   <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            wstrb_reg     <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
            rsp_rdata_reg <= '0;
        end else begin
            if (accept) begin
                addr_reg  <= req_addr;
                wdata_reg <= req_wdata;
                wstrb_reg <= req_wstrb;
            end
            if (accept && req_we) begin
                awvalid_reg <= 1'b1;
                wvalid_reg  <= 1'b1;
            end else begin
                if (s_axil_io_awready) awvalid_reg <= 1'b0;
                if (s_axil_io_wready)  wvalid_reg  <= 1'b0;
            end
            if (accept && !req_we) begin
                arvalid_reg <= 1'b1;
            end else if (s_axil_io_arready) begin
                arvalid_reg <= 1'b0;
            end
            rsp_valid_reg <= b_hs || r_hs;
            if (b_hs) rsp_err_reg <= s_axil_io_bresp[1];
            if (r_hs) begin
                rsp_err_reg   <= s_axil_io_rresp[1];
                rsp_rdata_reg <= s_axil_io_rdata;
            end
        end
    end

    assign rsp_valid         = rsp_valid_reg;
    assign rsp_err           = rsp_err_reg;
    assign rsp_rdata         = rsp_rdata_reg;
    assign s_axil_io_awaddr  = addr_reg;
    assign s_axil_io_araddr  = addr_reg;
    assign s_axil_io_awprot  = PROT;
    assign s_axil_io_arprot  = PROT;
    assign s_axil_io_awvalid = awvalid_reg;
    assign s_axil_io_wvalid  = wvalid_reg;
    assign s_axil_io_arvalid = arvalid_reg;
    assign s_axil_io_wdata   = wdata_reg;
    assign s_axil_io_wstrb   = wstrb_reg;

endmodule

// File: tb/tb_rv32i_mem_axil_bridge.sv
// Directed bench for rv32i_mem_axil_bridge: the bench plays the MEM stage and a scripted AXI-Lite slave.
`timescale 1ns/1ps
module tb_rv32i_mem_axil_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [3:0]  req_wstrb = '0;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] awaddr, wdata, araddr, rdata = '0;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, awready = 1'b0, wvalid, wready = 1'b0;
    logic [1:0]  bresp = '0, rresp = '0;
    logic        bvalid = 1'b0, bready, arvalid, arready = 1'b0, rvalid = 1'b0, rready;

    int checks = 0;
    int passed = 0;
    int rsp_count = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (rsp_valid) rsp_count++;

    rv32i_mem_axil_bridge dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .s_axil_io_awaddr(awaddr), .s_axil_io_awprot(awprot),
        .s_axil_io_awvalid(awvalid), .s_axil_io_awready(awready),
        .s_axil_io_wdata(wdata), .s_axil_io_wstrb(wstrb),
        .s_axil_io_wvalid(wvalid), .s_axil_io_wready(wready),
        .s_axil_io_bresp(bresp), .s_axil_io_bvalid(bvalid), .s_axil_io_bready(bready),
        .s_axil_io_araddr(araddr), .s_axil_io_arprot(arprot),
        .s_axil_io_arvalid(arvalid), .s_axil_io_arready(arready),
        .s_axil_io_rdata(rdata), .s_axil_io_rresp(rresp),
        .s_axil_io_rvalid(rvalid), .s_axil_io_rready(rready)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        tick();
        checks++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready got %0b want 1", req_ready); else passed++;
        checks++; if ({awvalid, wvalid, arvalid, bready, rready} !== 5'b0)
            $display("FAIL reset_axi_ctrl got %05b want 00000", {awvalid, wvalid, arvalid, bready, rready}); else passed++;
        checks++; if ({rsp_valid, rsp_err} !== 2'b00) $display("FAIL reset_rsp got %02b want 00", {rsp_valid, rsp_err}); else passed++;
        checks++; if ({rsp_rdata, awaddr, wdata, wstrb} !== 100'h0)
            $display("FAIL reset_data got %h/%h/%h/%h want zeros", rsp_rdata, awaddr, wdata, wstrb); else passed++;
        checks++; if ({awprot, arprot} !== 6'b0) $display("FAIL reset_prot got %06b want 000000", {awprot, arprot}); else passed++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_store_zero_wait();
        int base;
        base = rsp_count;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h1000; req_wdata = 32'hDEADBEEF; req_wstrb = 4'hF;
        awready = 1'b1; wready = 1'b1;
        tick();
        req_valid = 1'b0;
        checks++; if ({awvalid, wvalid, arvalid} !== 3'b110) $display("FAIL st1_valids got %03b want 110", {awvalid, wvalid, arvalid}); else passed++;
        checks++; if ({awaddr, wdata, wstrb} !== {32'h1000, 32'hDEADBEEF, 4'hF})
            $display("FAIL st1_payload got %h %h %h want 1000 deadbeef f", awaddr, wdata, wstrb); else passed++;
        checks++; if (req_ready !== 1'b0) $display("FAIL st1_busy got %0b want 0", req_ready); else passed++;
        tick();
        awready = 1'b0; wready = 1'b0; bvalid = 1'b1; bresp = 2'b00;
        checks++; if ({awvalid, wvalid, bready, rsp_valid} !== 4'b0010)
            $display("FAIL st1_wresp got %04b want 0010", {awvalid, wvalid, bready, rsp_valid}); else passed++;
        tick();
        bvalid = 1'b0;
        checks++; if ({rsp_valid, rsp_err, req_ready, bready} !== 4'b1010)
            $display("FAIL st1_rsp got %04b want 1010", {rsp_valid, rsp_err, req_ready, bready}); else passed++;
        tick();
        checks++; if ((rsp_count - base) !== 1 || rsp_valid !== 1'b0)
            $display("FAIL st1_pulses got %0d/%0b want 1/0", rsp_count - base, rsp_valid); else passed++;
    endtask

    task automatic test_store_aw_delay();
        int base;
        base = rsp_count;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h1010; req_wdata = 32'hA5A50F0F; req_wstrb = 4'h0;
        wready = 1'b1;
        tick();
        req_valid = 1'b0;
        checks++; if ({awvalid, wvalid, wstrb} !== 6'b110000) $display("FAIL st2_start got %06b want 110000", {awvalid, wvalid, wstrb}); else passed++;
        for (int i = 2; i <= 4; i++) begin
            tick();
            wready = 1'b0;
            checks++; if ({awvalid, wvalid, awaddr} !== {2'b10, 32'h1010})
                $display("FAIL st2_hold_c%0d got %0b%0b %h want 10 1010", i, awvalid, wvalid, awaddr); else passed++;
        end
        awready = 1'b1;
        tick();
        awready = 1'b0; bvalid = 1'b1; bresp = 2'b00;
        checks++; if ({awvalid, bready} !== 2'b01) $display("FAIL st2_wresp got %02b want 01", {awvalid, bready}); else passed++;
        tick();
        bvalid = 1'b0;
        tick();
        tick();
        checks++; if ((rsp_count - base) !== 1) $display("FAIL st2_pulses got %0d want 1", rsp_count - base); else passed++;
    endtask

    task automatic test_load_err();
        int base;
        base = rsp_count;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h2004;
        arready = 1'b1;
        tick();
        req_valid = 1'b0;
        checks++; if ({arvalid, awvalid, wvalid, araddr} !== {3'b100, 32'h2004})
            $display("FAIL ld_ar got %0b%0b%0b %h want 100 2004", arvalid, awvalid, wvalid, araddr); else passed++;
        tick();
        arready = 1'b0; rvalid = 1'b1; rdata = 32'h12345678; rresp = 2'b10;
        checks++; if ({arvalid, rready} !== 2'b01) $display("FAIL ld_rdata_state got %02b want 01", {arvalid, rready}); else passed++;
        tick();
        rvalid = 1'b0; rdata = 32'h0;
        checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b11, 32'h12345678})
            $display("FAIL ld_rsp got %0b%0b %h want 11 12345678", rsp_valid, rsp_err, rsp_rdata); else passed++;
        tick();
        checks++; if ({rsp_valid, rsp_rdata} !== {1'b0, 32'h12345678} || (rsp_count - base) !== 1)
            $display("FAIL ld_hold got %0b %h cnt %0d want 0 12345678 cnt 1", rsp_valid, rsp_rdata, rsp_count - base); else passed++;
    endtask

    task automatic test_back_to_back();
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h1020; req_wdata = 32'h0000_00FF; req_wstrb = 4'h1;
        awready = 1'b1; wready = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        awready = 1'b0; wready = 1'b0; bvalid = 1'b1; bresp = 2'b00;
        tick();
        bvalid = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h3000;
        checks++; if ({rsp_valid, req_ready} !== 2'b11) $display("FAIL b2b_accept got %02b want 11", {rsp_valid, req_ready}); else passed++;
        tick();
        req_valid = 1'b0;
        checks++; if ({arvalid, rsp_valid, araddr} !== {2'b10, 32'h3000})
            $display("FAIL b2b_ar got %0b%0b %h want 10 3000", arvalid, rsp_valid, araddr); else passed++;
        arready = 1'b1;
        tick();
        arready = 1'b0; rvalid = 1'b1; rdata = 32'hCAFEF00D; rresp = 2'b00;
        tick();
        rvalid = 1'b0;
        checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 32'hCAFEF00D})
            $display("FAIL b2b_rsp got %0b%0b %h want 10 cafef00d", rsp_valid, rsp_err, rsp_rdata); else passed++;
        tick();
    endtask

    task automatic test_reset_in_wresp();
        int base;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h1030; req_wdata = 32'h55AA55AA; req_wstrb = 4'hF;
        awready = 1'b1; wready = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        awready = 1'b0; wready = 1'b0;
        checks++; if (bready !== 1'b1) $display("FAIL rst_pre_bready got %0b want 1", bready); else passed++;
        base = rsp_count;
        rst = 1'b1;
        #1;
        checks++; if ({bready, req_ready, awvalid, wvalid, rsp_valid} !== 5'b01000)
            $display("FAIL rst_async got %05b want 01000", {bready, req_ready, awvalid, wvalid, rsp_valid}); else passed++;
        checks++; if (rsp_rdata !== 32'h0) $display("FAIL rst_rdata got %h want 0", rsp_rdata); else passed++;
        tick();
        rst = 1'b0;
        bvalid = 1'b1;
        tick();
        bvalid = 1'b0;
        tick();
        checks++; if ((rsp_count - base) !== 0 || rsp_valid !== 1'b0 || req_ready !== 1'b1)
            $display("FAIL rst_no_rsp got cnt %0d rv %0b rr %0b want 0 0 1", rsp_count - base, rsp_valid, req_ready); else passed++;
    endtask

    task automatic test_hold_while_busy();
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h2008;
        arready = 1'b1;
        tick();
        req_we = 1'b1; req_addr = 32'h1040; req_wdata = 32'h11223344; req_wstrb = 4'hF;
        checks++; if ({arvalid, req_ready} !== 2'b10) $display("FAIL busy_ar got %02b want 10", {arvalid, req_ready}); else passed++;
        tick();
        arready = 1'b0;
        for (int i = 2; i <= 4; i++) begin
            checks++; if ({req_ready, awvalid, wvalid, arvalid, rready} !== 5'b00001)
                $display("FAIL busy_c%0d got %05b want 00001", i, {req_ready, awvalid, wvalid, arvalid, rready}); else passed++;
            tick();
        end
        rvalid = 1'b1; rdata = 32'h0BADF00D; rresp = 2'b00;
        checks++; if (req_ready !== 1'b0) $display("FAIL busy_c5 got %0b want 0", req_ready); else passed++;
        tick();
        rvalid = 1'b0;
        awready = 1'b1; wready = 1'b1;
        checks++; if ({rsp_valid, req_ready, awvalid, rsp_rdata} !== {3'b110, 32'h0BADF00D})
            $display("FAIL busy_rsp got %0b%0b%0b %h want 110 0badf00d", rsp_valid, req_ready, awvalid, rsp_rdata); else passed++;
        tick();
        req_valid = 1'b0;
        checks++; if ({awvalid, wvalid, awaddr, wdata} !== {2'b11, 32'h1040, 32'h11223344})
            $display("FAIL busy_second got %0b%0b %h %h want 11 1040 11223344", awvalid, wvalid, awaddr, wdata); else passed++;
        tick();
        awready = 1'b0; wready = 1'b0; bvalid = 1'b1; bresp = 2'b10;
        tick();
        bvalid = 1'b0; bresp = 2'b00;
        checks++; if ({rsp_valid, rsp_err} !== 2'b11) $display("FAIL busy_store_err got %02b want 11", {rsp_valid, rsp_err}); else passed++;
        tick();
    endtask

    initial begin
        test_reset();
        test_store_zero_wait();
        test_store_aw_delay();
        test_load_err();
        test_back_to_back();
        test_reset_in_wresp();
        test_hold_while_busy();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
